qspi_target: RTL and testbench
==============================

# qspi_target

Single-clock, oversampling QSPI target that replaces the dual-clock QSPI front end for designs where the system clock is at least 8× the host's QSPI clock. It synchronises `qspi_clk`, `qspi_ncs` and `qspi_io` into `clk`, decodes a header word, streams write payload into an internal RX FIFO, and streams read data from an internal TX FIFO after a configurable dummy phase. Width, lane count, FIFO depth, address-word count and dummy length are parameters. It sits between the board QSPI pins and the cartridge-side register/memory logic.

## Interface
- `DATA_W`, 16: word width; multiple of `IO_W`, 8..32.
- `IO_W`, 4: active lanes per QSPI clock: 1, 2 or 4.
- `DEPTH`, 8: RX and TX FIFO depth in words; power of two, ≥2.
- `ADDR_WORDS`, 1: words received after the header before the dummy phase on reads; 0..4.
- `DUMMY_CYCLES`, 4: QSPI clocks with the bus tristated before read data; 0..15.

- `clk` in 1: system clock; all logic is on its rising edge.
- `async_reset_n` in 1: asynchronous, active-low reset.
- `qspi_clk` in 1: host QSPI clock, asynchronous to `clk`; mode 0.
- `qspi_ncs` in 1: host chip select, active-low.
- `qspi_io` inout 4: data lanes; lanes `[IO_W-1:0]` are used, and unused lanes are always `z`.
- `rd_data` out DATA_W: head of the RX FIFO.
- `rd_valid` out 1: RX FIFO not empty.
- `rd_ready` in 1: pop; a word transfers when `rd_valid && rd_ready`.
- `wr_data` in DATA_W: word to send.
- `wr_valid` in 1: push request.
- `wr_ready` out 1: TX FIFO not full; a word transfers when `wr_valid && wr_ready`.
- `start` out 1: one-cycle pulse on a synchronised `qspi_ncs` falling edge.
- `done` out 1: one-cycle pulse on a synchronised `qspi_ncs` rising edge.
- `is_read` out 1: header of the current or last transaction had bit 0 = 0.
- `err_ovf` out 1: sticky RX overflow flag.
- `err_udf` out 1: sticky TX underrun flag.

## Operation
- Input synchronisers:
  - `qspi_clk`, `qspi_ncs` and `qspi_io` each pass through 2 flops, plus a third flop for edge detection.
  - A rise of the synchronised `qspi_clk` is a sample event. A fall is a drive event.
- `start`:
  - Flushes both FIFOs in the same cycle and clears `err_ovf`/`err_udf`.
  - Pushes from the user in that cycle are dropped.
- Bit counter:
  - Counts sample events modulo `DATA_W/IO_W`.
  - A word completes on the last beat; new lanes shift in at the LSB end, MSB first.
- States:
  - IDLE: while `ncs` is high.
  - HDR: the first word is pushed to RX. `is_read` ← `~word[0]`. If the header is a write, go to WRITE. Otherwise go to ADDR, or to DUMMY when `ADDR_WORDS`=0.
  - WRITE: every completed word is pushed to RX.
  - ADDR: `ADDR_WORDS` words are pushed to RX, then go to DUMMY.
  - DUMMY: count `DUMMY_CYCLES` sample events with the bus tristated, then go to SEND. With 0 cycles, SEND is entered immediately.
  - SEND:
    - On the first drive event of each word, pop TX, load the shift register and drive the top `IO_W` bits.
    - Later drive events shift by `IO_W`.
    - The output enable is registered and asserted from the first drive event in SEND.
- Synchronised `ncs` high in any state returns to IDLE within 1 clk, releases the bus, pulses `done`, and zeroes the bit counter. A partial word is discarded. FIFO contents are kept.
- RX full at word completion: the word is dropped and `err_ovf` is set. Empty/full pointers are `log2(DEPTH)+1` bits with wrap-around.
- TX empty at a SEND word load: all-zero data is driven for that word and `err_udf` is set.
- Simultaneous user pop and internal push, or push and internal pop, are both honoured in the same cycle.
- `async_reset_n` low:
  - State → IDLE; FIFOs, counters and flags cleared.
  - `qspi_io` = `z`.
  - Outputs: `rd_valid`=0, `wr_ready`=1, `start`=`done`=`is_read`=`err_*`=0, `rd_data`=0.

## Timing
- Required: `clk` ≥ 8 × `qspi_clk`. Each QSPI clock phase must be ≥4 clk.
- Pin to sample: 3 clk from a `qspi_clk` rise.
- RX: a pushed word appears on `rd_valid` 1 clk after the sample event that completes it, i.e. 4 clk after the pin edge.
- TX: the drive update reaches the pins ≤4 clk after a `qspi_clk` fall, so data is valid before the next rise.
- `start` and `done` occur 3 clk after the respective `ncs` edge.
- FIFOs are first-word-fall-through. Pop-to-next-`rd_data` is 1 clk.

## Configuration
- `QSPI_TARGET_ERR_EN` defined: the overflow/underrun detection logic is built and `err_ovf`/`err_udf` behave as specified.
- Undefined: the detection logic is removed and both ports are tied to 0. Drop and zero-fill behaviour is unchanged.

## Test plan
- Write, default parameters: header 0x0001, then payload 0xA5C3, 0x1234 → RX pops 0x0001, 0xA5C3, 0x1234; `is_read`=0; `done` pulse; bus never driven.
- Read, defaults: TX preloaded with 0xBEEF, 0x0F0F; header 0x0000, address 0x0040 → RX holds 0x0000, 0x0040; bus `z` for 4 clocks; host samples 0xBEEF then 0x0F0F; `is_read`=1.
- `IO_W`=1, `DATA_W`=8, `DUMMY_CYCLES`=0: header 0x02 and address 0x11 (`ADDR_WORDS`=1), TX holds 0x5A → 0x5A is shifted out MSB first on `io[0]` only, starting at the next fall.
- Overflow, `DEPTH`=2 with `rd_ready`=0: header plus 2 words → RX holds the first 2 words, the third is dropped, `err_ovf`=1. A new `start` clears the flag.
- Underrun: read transaction with an empty TX → 0x0000 is shifted out and `err_udf`=1. With the macro undefined, `err_udf` stays 0.
- Abort: raise `ncs` mid-word, then assert and release `async_reset_n` mid-SEND → partial word discarded and `done` pulsed; after reset, the reset values are reached immediately and the bus is `z`.

Source files
------------

// File: rtl/qspi_target.sv
// Oversampling single-clock QSPI target: synchronised pins, header/addr/dummy decode, RX/TX FIFOs.
// Define QSPI_TARGET_ERR_EN to build the sticky err_ovf/err_udf detection; otherwise both read 0.
module qspi_target #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned IO_W         = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_WORDS   = 1,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              async_reset_n,
  input  logic              qspi_clk,
  input  logic              qspi_ncs,
  inout  tri   [3:0]        qspi_io,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              start,
  output logic              done,
  output logic              is_read,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int unsigned BEATS = DATA_W / IO_W;
  localparam int unsigned CW    = $clog2(BEATS);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);
  localparam logic [2:0]    ADDR_LAST = (ADDR_WORDS == 0)   ? 3'd0 : 3'(ADDR_WORDS - 1);
  localparam logic [3:0]    DUM_LAST  = (DUMMY_CYCLES == 0) ? 4'd0 : 4'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WRITE, S_ADDR, S_DUMMY, S_SEND} state_e;

  // ---------------- input synchronisers ----------------
  logic [2:0]      sclk_q, sncs_q;
  logic [IO_W-1:0] sio1_q, sio2_q;
  logic            unused_io;

  assign unused_io = ^qspi_io;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sclk_q <= '0;
      sncs_q <= '1;
      sio1_q <= '0;
      sio2_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], qspi_clk};
      sncs_q <= {sncs_q[1:0], qspi_ncs};
      sio1_q <= qspi_io[IO_W-1:0];
      sio2_q <= sio1_q;
    end
  end

  logic sample_ev, drive_ev, ncs_hi, ncs_fall, ncs_rise;
  assign sample_ev = sclk_q[1] & ~sclk_q[2];
  assign drive_ev  = ~sclk_q[1] & sclk_q[2];
  assign ncs_hi    = sncs_q[1];
  assign ncs_fall  = ~sncs_q[1] & sncs_q[2];
  assign ncs_rise  = sncs_q[1] & ~sncs_q[2];

  // ---------------- FIFO storage ----------------
  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [AW:0]       rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic [DATA_W-1:0] tx_head;

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_head  = tx_mem_q[tx_rp_q[AW-1:0]];

  // ---------------- protocol FSM ----------------
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, tx_cnt_q, tx_cnt_d;
  logic [DATA_W-IO_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]      word_next, push_word_q;
  logic [DATA_W-1:0]      tx_sh_q, tx_sh_d;
  logic [2:0]             addr_q, addr_d;
  logic [3:0]             dum_q, dum_d;
  logic                   is_read_q, is_read_d;
  logic                   push_q, push_d;
  logic                   oe_q, oe_d;
  logic                   start_q, done_q;
  logic                   word_done, tx_load;

  assign word_next = {rx_sh_q, sio2_q};
  assign word_done = sample_ev && (cnt_q == BEAT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sh_d   = rx_sh_q;
    addr_d    = addr_q;
    dum_d     = dum_q;
    is_read_d = is_read_q;
    push_d    = 1'b0;
    tx_cnt_d  = tx_cnt_q;
    tx_sh_d   = tx_sh_q;
    oe_d      = oe_q;
    tx_load   = 1'b0;
    if (ncs_hi) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      tx_cnt_d = '0;
      addr_d   = '0;
      dum_d    = '0;
      oe_d     = 1'b0;
    end else begin
      if (sample_ev && ((state_q == S_HDR) || (state_q == S_WRITE) || (state_q == S_ADDR))) begin
        rx_sh_d = word_next[DATA_W-IO_W-1:0];
        cnt_d   = word_done ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE:  state_d = S_HDR;
        S_HDR: begin
          if (word_done) begin
            push_d    = 1'b1;
            is_read_d = ~word_next[0];
            if (word_next[0])           state_d = S_WRITE;
            else if (ADDR_WORDS != 0)   state_d = S_ADDR;
            else if (DUMMY_CYCLES != 0) state_d = S_DUMMY;
            else                        state_d = S_SEND;
          end
        end
        S_WRITE: push_d = word_done;
        S_ADDR: begin
          if (word_done) begin
            push_d = 1'b1;
            if (addr_q == ADDR_LAST) begin
              addr_d  = '0;
              state_d = (DUMMY_CYCLES != 0) ? S_DUMMY : S_SEND;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
        S_DUMMY: begin
          if (sample_ev) begin
            if (dum_q == DUM_LAST) begin
              dum_d   = '0;
              state_d = S_SEND;
            end else begin
              dum_d = dum_q + 1'b1;
            end
          end
        end
        S_SEND: begin
          // Word boundaries are tracked on drive events so the load lands on the first fall of each word.
          if (drive_ev) begin
            oe_d = 1'b1;
            if (tx_cnt_q == '0) begin
              tx_load = 1'b1;
              tx_sh_d = tx_empty ? '0 : tx_head;
            end else begin
              tx_sh_d = tx_sh_q << IO_W;
            end
            tx_cnt_d = (tx_cnt_q == BEAT_LAST) ? '0 : tx_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      addr_q      <= '0;
      dum_q       <= '0;
      is_read_q   <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      oe_q        <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      addr_q      <= addr_d;
      dum_q       <= dum_d;
      is_read_q   <= is_read_d;
      push_q      <= push_d;
      push_word_q <= word_next;
      oe_q        <= oe_d;
      start_q     <= ncs_fall;
      done_q      <= ncs_rise;
    end
  end

  // ---------------- FIFO pointers and storage ----------------
  logic rx_wr, rx_pop, tx_push, tx_pop;
  assign rx_wr   = push_q & ~rx_full;
  assign rx_pop  = ~rx_empty & rd_ready;
  assign tx_push = wr_valid & ~tx_full;
  assign tx_pop  = tx_load & ~tx_empty;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rx_mem_q[i] <= '0;
        tx_mem_q[i] <= '0;
      end
    end else if (start_q) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (rx_wr) begin
        rx_mem_q[rx_wp_q[AW-1:0]] <= push_word_q;
        rx_wp_q <= rx_wp_q + 1'b1;
      end
      if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
      if (tx_push) begin
        tx_mem_q[tx_wp_q[AW-1:0]] <= wr_data;
        tx_wp_q <= tx_wp_q + 1'b1;
      end
      if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
    end
  end

  // ---------------- error flags ----------------
`ifdef QSPI_TARGET_ERR_EN
  logic err_ovf_q, err_udf_q;
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else if (start_q) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (push_q && rx_full)   err_ovf_q <= 1'b1;
      if (tx_load && tx_empty) err_udf_q <= 1'b1;
    end
  end
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign rd_valid = ~rx_empty;
  assign rd_data  = rx_empty ? '0 : rx_mem_q[rx_rp_q[AW-1:0]];
  assign wr_ready = ~tx_full;
  assign start    = start_q;
  assign done     = done_q;
  assign is_read  = is_read_q;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    if (g < IO_W) begin : g_act
      assign qspi_io[g] = oe_q ? tx_sh_q[DATA_W-IO_W+g] : 1'bz;
    end else begin : g_off
      assign qspi_io[g] = 1'bz;
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Randomised host-level bench for qspi_target: transaction model predicts RX words, read data and flags.
module tb_qspi_target;
  localparam int DW = 16, IOW = 4, DEP = 8, AWDS = 1, DUM = 4, BEATS = DW / IOW;
`ifdef QSPI_TARGET_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, qclk = 1'b0, ncs = 1'b1;
  logic          host_oe = 1'b0;
  logic [3:0]    host_d = '0;
  wire  [3:0]    qio;
  logic [DW-1:0] rd_data, wr_data;
  logic          rd_valid, rd_ready, wr_valid, wr_ready;
  logic          start, done, is_read, err_ovf, err_udf;

  assign qio = host_oe ? host_d : 4'bzzzz;

  qspi_target #(.DATA_W(DW), .IO_W(IOW), .DEPTH(DEP), .ADDR_WORDS(AWDS), .DUMMY_CYCLES(DUM)) dut (
    .clk(clk), .async_reset_n(rst_n), .qspi_clk(qclk), .qspi_ncs(ncs), .qspi_io(qio),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .start(start), .done(done), .is_read(is_read), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int start_cnt = 0, done_cnt = 0, drv_cnt = 0;
  logic [DW-1:0] hq[$];
  logic [DW-1:0] txq[$];

  always @(negedge clk) begin
    if (start)      start_cnt <= start_cnt + 1;
    if (done)       done_cnt  <= done_cnt + 1;
    if (dut.oe_q)   drv_cnt   <= drv_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int nb);
    for (int b = 0; b < nb; b++) begin
      host_d  = 4'(w >> (DW - IOW * (b + 1)));
      host_oe = 1'b1;
      half(); qclk = 1'b1;
      half(); qclk = 1'b0;
    end
  endtask

  task automatic read_word(output logic [DW-1:0] w, input int nb);
    w = '0;
    for (int b = 0; b < nb; b++) begin
      half();
      w = (w << IOW) | DW'(qio[IOW-1:0]);
      qclk = 1'b1;
      half(); qclk = 1'b0;
    end
  endtask

  task automatic dummy_phase();
    for (int d = 0; d < DUM; d++) begin
      half();
      check("dummy_bus_z", {31'd0, dut.oe_q}, 0);
      qclk = 1'b1;
      half(); qclk = 1'b0;
    end
  endtask

  task automatic push_tx();
    int n;
    foreach (txq[i]) begin
      wr_data  = txq[i];
      wr_valid = 1'b1;
      n = 0;
      while (!wr_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) check("tx_push_timeout", 0, 1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int nexp);
    int n;
    for (int i = 0; i < nexp; i++) begin
      n = 0;
      while (!rd_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin check("rx_timeout", 0, 1); return; end
      check("rx_word", rd_data, hq[i]);
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
    check("rx_empty_after", {31'd0, rd_valid}, 0);
  endtask

  // One complete transaction from hq/txq; expectations derived from the protocol rules.
  task automatic run_txn(input int n_read);
    int s0, d0, v0, nexp;
    bit rd;
    logic [DW-1:0] w;
    s0 = start_cnt; d0 = done_cnt; v0 = drv_cnt;
    rd = ~hq[0][0];
    ncs = 1'b0;
    half(); half();
    push_tx();
    foreach (hq[i]) send_word(hq[i], BEATS);
    host_oe = 1'b0;
    if (rd) begin
      dummy_phase();
      for (int j = 0; j < n_read; j++) begin
        read_word(w, BEATS);
        check("tx_word", w, (j < txq.size()) ? txq[j] : '0);
      end
    end
    half(); ncs = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("start_pulse", start_cnt - s0, 1);
    check("done_pulse", done_cnt - d0, 1);
    check("is_read", {31'd0, is_read}, {31'd0, rd});
    if (!rd) check("write_bus_idle", drv_cnt - v0, 0);
    check("err_ovf", {31'd0, err_ovf}, {31'd0, ERR && (hq.size() > DEP)});
    check("err_udf", {31'd0, err_udf}, {31'd0, ERR && rd && (n_read > txq.size())});
    nexp = (hq.size() > DEP) ? DEP : hq.size();
    drain(nexp);
  endtask

  initial begin
    logic [DW-1:0] w;
    int d0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_wr_ready", {31'd0, wr_ready}, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_flags", {27'd0, start, done, is_read, err_ovf, err_udf}, 0);
    check("rst_bus_z", {31'd0, dut.oe_q}, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // write
    hq = '{16'h0001, 16'hA5C3, 16'h1234}; txq = {};
    run_txn(0);
    // read
    hq = '{16'h0000, 16'h0040}; txq = '{16'hBEEF, 16'h0F0F};
    run_txn(2);
    // overflow: header + 9 words into 8 entries
    hq = '{16'h0003};
    for (int i = 0; i < 9; i++) hq.push_back(DW'($urandom));
    txq = {};
    run_txn(0);
    // a fresh start clears the flag
    hq = '{16'h0101, 16'h7777}; txq = {};
    run_txn(0);
    // underrun
    hq = '{16'h0002, 16'h0011}; txq = {};
    run_txn(1);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        hq = '{DW'($urandom) & ~DW'(1), DW'($urandom)};
        txq = {};
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) txq.push_back(DW'($urandom));
        run_txn(int'($urandom_range(1, 3)));
      end else begin
        hq = '{DW'($urandom) | DW'(1)};
        for (int k = 0; k < int'($urandom_range(0, 4)); k++) hq.push_back(DW'($urandom));
        txq = {};
        run_txn(0);
      end
    end

    // abort mid-word: only the header survives
    d0 = done_cnt;
    hq = '{16'h0005};
    ncs = 1'b0; half(); half();
    send_word(16'h0005, BEATS);
    send_word(16'hFFFF, 2);
    host_oe = 1'b0;
    half(); ncs = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("abort_done", done_cnt - d0, 1);
    drain(1);

    // async reset during SEND
    txq = '{16'hCAFE};
    ncs = 1'b0; half(); half();
    push_tx();
    send_word(16'h0000, BEATS);
    send_word(16'h0010, BEATS);
    host_oe = 1'b0;
    dummy_phase();
    read_word(w, 2);
    check("partial_tx", w, 32'h00CA);
    check("send_bus_driven", {31'd0, dut.oe_q}, 1);
    rst_n = 1'b0; #1;
    check("rst_mid_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_mid_wr_ready", {31'd0, wr_ready}, 1);
    check("rst_mid_flags", {28'd0, done, is_read, err_ovf, err_udf}, 0);
    check("rst_mid_bus_z", {31'd0, dut.oe_q}, 0);
    check("rst_mid_rd_data", rd_data, 0);
    ncs = 1'b1; qclk = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    hq = '{16'h4321, 16'h9ABC}; txq = {};
    run_txn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
